// File: rtl/uart_command_decoder.sv
// uart_command_decoder
// Turns a stream of UART bytes into single 32-bit device-bus transactions.
// Packet: cmd (bit7=1 write), device id, addr hi, addr lo, [4 data bytes MSB first].
// Read results go back over the UART TX handshake as 4 bytes, MSB first.
// Optional: define UART_CMD_WRITE_ACK_EN to send an 8'hA5 ack after each write.
module uart_command_decoder #(
    parameter int unsigned INTERBYTE_TIMEOUT = 4096,
    parameter int unsigned READ_TIMEOUT      = 256,
    parameter logic [31:0] TIMEOUT_FILL      = 32'hFFFF_FFFF
) (
    input  logic        iGlobalClock,
    input  logic        iGlobalReset,
    input  logic        iUartByteAvailable,
    input  logic [7:0]  iUartRx,
    input  logic        iUartTxReady,
    output logic        oUartTxByteAvailable,
    output logic [7:0]  oUartTx,
    output logic [7:0]  oBusDeviceId,
    output logic [15:0] oBusAddress,
    output logic [31:0] oBusWriteData,
    output logic        oBusWriteEnable,
    output logic        oBusReadEnable,
    input  logic [31:0] iBusReadData,
    input  logic        iBusReadDataValid,
    output logic        oBusy,
    output logic        oProtocolError
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEV       = 4'd1;
    localparam logic [3:0] S_ADDR_H    = 4'd2;
    localparam logic [3:0] S_ADDR_L    = 4'd3;
    localparam logic [3:0] S_DATA      = 4'd4;
    localparam logic [3:0] S_WRITE     = 4'd5;
    localparam logic [3:0] S_READ_REQ  = 4'd6;
    localparam logic [3:0] S_READ_WAIT = 4'd7;
    localparam logic [3:0] S_TX        = 4'd8;
    localparam logic [3:0] S_TX_GAP    = 4'd9;

    localparam int unsigned IB_W = $clog2(INTERBYTE_TIMEOUT + 1);
    localparam int unsigned RD_W = $clog2(READ_TIMEOUT + 1);

    logic [3:0]      state;
    logic            rx_prev;
    logic            accept;
    logic            collecting;
    logic            ib_expired;
    logic [IB_W-1:0] ib_cnt;
    logic [RD_W-1:0] rd_cnt;
    logic [1:0]      byte_cnt;
    logic            is_write;
    logic [31:0]     tx_shift;
    logic [2:0]      tx_left;

    assign accept          = iUartByteAvailable & ~rx_prev;
    assign collecting      = (state == S_DEV) || (state == S_ADDR_H) ||
                             (state == S_ADDR_L) || (state == S_DATA);
    assign ib_expired      = collecting && !accept &&
                             (ib_cnt == IB_W'(INTERBYTE_TIMEOUT - 1));
    assign oBusWriteEnable = (state == S_WRITE);
    assign oBusReadEnable  = (state == S_READ_REQ);
    assign oBusy           = (state != S_IDLE);

    // Previous byte-available level for rising-edge accept detection
    always_ff @(posedge iGlobalClock or posedge iGlobalReset) begin
        if (iGlobalReset) rx_prev <= 1'b0;
        else              rx_prev <= iUartByteAvailable;
    end

    // Inter-byte gap counter: runs only while collecting, cleared by every accept
    always_ff @(posedge iGlobalClock or posedge iGlobalReset) begin
        if (iGlobalReset)               ib_cnt <= '0;
        else if (accept || !collecting) ib_cnt <= '0;
        else                            ib_cnt <= ib_cnt + 1'b1;
    end

    // Packet assembly, bus sequencing and response transmission
    always_ff @(posedge iGlobalClock or posedge iGlobalReset) begin
        if (iGlobalReset) begin
            state                <= S_IDLE;
            rd_cnt               <= '0;
            byte_cnt             <= '0;
            is_write             <= 1'b0;
            tx_shift             <= '0;
            tx_left              <= '0;
            oUartTxByteAvailable <= 1'b0;
            oUartTx              <= '0;
            oBusDeviceId         <= '0;
            oBusAddress          <= '0;
            oBusWriteData        <= '0;
            oProtocolError       <= 1'b0;
        end else begin
            oUartTxByteAvailable <= 1'b0;
            oProtocolError       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_write <= iUartRx[7];
                        state    <= S_DEV;
                    end
                end
                S_DEV: begin
                    if (accept) begin
                        oBusDeviceId <= iUartRx;
                        state        <= S_ADDR_H;
                    end else if (ib_expired) begin
                        oProtocolError <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_ADDR_H: begin
                    if (accept) begin
                        oBusAddress[15:8] <= iUartRx;
                        state             <= S_ADDR_L;
                    end else if (ib_expired) begin
                        oProtocolError <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_ADDR_L: begin
                    if (accept) begin
                        oBusAddress[7:0] <= iUartRx;
                        byte_cnt         <= '0;
                        state            <= is_write ? S_DATA : S_READ_REQ;
                    end else if (ib_expired) begin
                        oProtocolError <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        oBusWriteData <= {oBusWriteData[23:0], iUartRx};
                        byte_cnt      <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) state <= S_WRITE;
                    end else if (ib_expired) begin
                        oProtocolError <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_WRITE: begin
`ifdef UART_CMD_WRITE_ACK_EN
                    tx_shift <= {8'hA5, 24'h000000};
                    tx_left  <= 3'd1;
                    state    <= S_TX;
`else
                    state    <= S_IDLE;
`endif
                end
                S_READ_REQ: begin
                    rd_cnt <= '0;
                    state  <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (iBusReadDataValid) begin
                        tx_shift <= iBusReadData;
                        tx_left  <= 3'd4;
                        state    <= S_TX;
                    end else if (rd_cnt == RD_W'(READ_TIMEOUT - 1)) begin
                        tx_shift       <= TIMEOUT_FILL;
                        tx_left        <= 3'd4;
                        oProtocolError <= 1'b1;
                        state          <= S_TX;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                S_TX: begin
                    if (iUartTxReady) begin
                        oUartTx              <= tx_shift[31:24];
                        oUartTxByteAvailable <= 1'b1;
                        tx_shift             <= {tx_shift[23:0], 8'h00};
                        tx_left              <= tx_left - 3'd1;
                        state                <= S_TX_GAP;
                    end
                end
                S_TX_GAP: begin
                    state <= (tx_left == 3'd0) ? S_IDLE : S_TX;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_command_decoder.sv
// Self-checking bench for uart_command_decoder: directed scenarios plus
// randomized packets, checked against a transaction-level reference model.
module tb_uart_command_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_avail = 1'b0;
    logic [7:0]  rx = '0;
    logic        tx_ready = 1'b1;
    logic        tx_avail;
    logic [7:0]  tx;
    logic [7:0]  dev_id;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic        busy;
    logic        perr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  obs_tx[$];
    logic [7:0]  exp_tx[$];
    logic [55:0] obs_wr[$];
    logic [55:0] exp_wr[$];
    int obs_err = 0, exp_err = 0;
    int obs_rd = 0, exp_rd = 0;

    always #5 clk = ~clk;

    uart_command_decoder #(
        .INTERBYTE_TIMEOUT(4096),
        .READ_TIMEOUT(256),
        .TIMEOUT_FILL(32'hFFFF_FFFF)
    ) dut (
        .iGlobalClock(clk),
        .iGlobalReset(rst),
        .iUartByteAvailable(byte_avail),
        .iUartRx(rx),
        .iUartTxReady(tx_ready),
        .oUartTxByteAvailable(tx_avail),
        .oUartTx(tx),
        .oBusDeviceId(dev_id),
        .oBusAddress(addr),
        .oBusWriteData(wdata),
        .oBusWriteEnable(we),
        .oBusReadEnable(re),
        .iBusReadData(rdata),
        .iBusReadDataValid(rvalid),
        .oBusy(busy),
        .oProtocolError(perr)
    );

    // Observe DUT activity on the falling edge, one entry per high cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_avail) obs_tx.push_back(tx);
            if (we)       obs_wr.push_back({dev_id, addr, wdata});
            if (perr)     obs_err++;
            if (re)       obs_rd++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: what each packet should produce at transaction level
    task automatic model_write(input logic [7:0] d, input logic [15:0] a, input logic [31:0] w);
        exp_wr.push_back({d, a, w});
`ifdef UART_CMD_WRITE_ACK_EN
        exp_tx.push_back(8'hA5);
`endif
    endtask

    task automatic model_read(input logic [31:0] value);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(8'((value >> (8 * k)) & 32'hFF));
        exp_rd++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            check({tag, "_wr"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
        check({tag, "_tx_count"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            check({tag, "_tx"}, 64'(obs_tx[i]), 64'(exp_tx[i]));
        check({tag, "_err"}, 64'(obs_err), 64'(exp_err));
        check({tag, "_rd"}, 64'(obs_rd), 64'(exp_rd));
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        rx = b; byte_avail = 1'b1;
        repeat (hold) @(posedge clk);
        #1 byte_avail = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Final byte of a packet: the strobe must be visible right after its accept edge
    task automatic send_last(input logic [7:0] b, input int hold, input bit wr, input string tag);
        @(posedge clk); #1;
        rx = b; byte_avail = 1'b1;
        @(posedge clk); #1;
        check(tag, wr ? 64'(we) : 64'(re), 64'd1);
        repeat (hold - 1) @(posedge clk);
        #1 byte_avail = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [15:0] a, input logic [31:0] w,
                            input int hold, input int gap);
        send_byte({1'b1, 7'($urandom)}, hold, gap);
        send_byte(d, hold, gap);
        send_byte(a[15:8], hold, gap);
        send_byte(a[7:0], hold, gap);
        send_byte(w[31:24], hold, gap);
        send_byte(w[23:16], hold, gap);
        send_byte(w[15:8], hold, gap);
        send_last(w[7:0], hold, 1'b1, "wr_latency");
        model_write(d, a, w);
        wait_idle("wr_idle");
    endtask

    task automatic do_read(input logic [7:0] d, input logic [15:0] a, input logic [31:0] value,
                           input int lat, input int hold, input int gap, input bit tmo);
        send_byte({1'b0, 7'($urandom)}, hold, gap);
        send_byte(d, hold, gap);
        send_byte(a[15:8], hold, gap);
        send_last(a[7:0], hold, 1'b0, "rd_latency");
        if (tmo) begin
            model_read(32'hFFFF_FFFF);
            exp_err++;
        end else begin
            repeat (lat) @(posedge clk);
            #1 rdata = value; rvalid = 1'b1;
            @(posedge clk);
            #1 rvalid = 1'b0; rdata = $urandom;
            model_read(value);
        end
        wait_idle("rd_idle");
    endtask

    initial begin
        logic [31:0] r;
        int n;

        // Reset state
        #1;
        check("reset_outputs", 64'({tx_avail, tx, dev_id, addr, wdata, we, re, busy, perr}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic write and read
        do_write(8'h01, 16'h0004, 32'hDEAD_BEEF, 1, 1);
        compare_all("write_basic");
        do_read(8'h02, 16'h0001, 32'h1234_5678, 3, 1, 1, 1'b0);
        compare_all("read_basic");

        // Held level: 10 cycles high, 10 low per byte
        do_write(8'h01, 16'h0004, 32'hDEAD_BEEF, 10, 10);
        do_read(8'h02, 16'h0001, 32'h1234_5678, 3, 10, 10, 1'b0);
        compare_all("held_level");

        // Valid pulses while idle must be ignored
        @(posedge clk); #1 rdata = 32'hBAD0_BAD0; rvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rvalid = 1'b0;
        check("valid_idle_busy", 64'(busy), 64'd0);

        // Inter-byte timeout, then a clean read
        send_byte(8'h80, 2, 0);
        send_byte(8'h01, 2, 0);
        repeat (4096 + 5) @(posedge clk);
        #1;
        exp_err++;
        check("ib_timeout_err", 64'(obs_err), 64'(exp_err));
        check("ib_timeout_busy", 64'(busy), 64'd0);
        do_read(8'h07, 16'hA55A, 32'hCAFE_F00D, 2, 1, 0, 1'b0);
        compare_all("ib_timeout");

        // Read timeout returns the fill word
        do_read(8'h03, 16'h0010, 32'h0, 0, 1, 0, 1'b1);
        compare_all("read_timeout");

        // Byte arriving during READ_WAIT is dropped
        send_byte(8'h00, 1, 0);
        send_byte(8'h05, 1, 0);
        send_byte(8'h00, 1, 0);
        send_last(8'h20, 1, 1'b0, "drop_rd_latency");
        send_byte(8'h80, 1, 0);
        repeat (2) @(posedge clk);
        #1 rdata = 32'h0BAD_C0DE; rvalid = 1'b1;
        @(posedge clk);
        #1 rvalid = 1'b0;
        model_read(32'h0BAD_C0DE);
        wait_idle("drop_idle");
        compare_all("drop_in_wait");

        // TX backpressure mid-response
        send_byte(8'h00, 1, 0);
        send_byte(8'h09, 1, 0);
        send_byte(8'h12, 1, 0);
        send_last(8'h34, 1, 1'b0, "bp_rd_latency");
        repeat (3) @(posedge clk);
        #1 rdata = 32'h8899_AABB; rvalid = 1'b1;
        @(posedge clk);
        #1 rvalid = 1'b0;
        n = 0;
        while (tx_avail !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_first_strobe", 64'(tx_avail), 64'd1);
        tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_stalled_count", 64'(obs_tx.size()), 64'd1);
        tx_ready = 1'b1;
        model_read(32'h8899_AABB);
        wait_idle("bp_idle");
        compare_all("backpressure");

        // Reset during DATA
        send_byte(8'h80, 1, 0);
        send_byte(8'h04, 1, 0);
        send_byte(8'h00, 1, 0);
        send_byte(8'h08, 1, 0);
        send_byte(8'h11, 1, 0);
        send_byte(8'h22, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outputs", 64'({tx_avail, tx, dev_id, addr, wdata, we, re, busy, perr}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        compare_all("mid_reset");

        // Randomized packets
        for (int i = 0; i < 12; i++) begin
            int hold, gap, lat;
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(0, 3);
            lat  = $urandom_range(1, 8);
            r    = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom), 16'($urandom), r, hold, gap);
            else
                do_read(8'($urandom), 16'($urandom), r, lat, hold, gap, 1'b0);
        end
        compare_all("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
